// File: rtl/bullet_pkg.sv
// Shared types, constants and the per-axis motion rule for the bullet pool.
// Slot field widths are fixed here; the pool's width parameters must match them.
package bullet_pkg;

    localparam int SLOT_COORD_W  = 8;
    localparam int SLOT_VEL_W    = 4;
    localparam int SLOT_COLOR_W  = 3;
    localparam int FIELD_MAX_DEF = 200;

    typedef enum logic [SLOT_COLOR_W-1:0] {
        COLOR_WHITE = 3'd0,
        COLOR_GREEN = 3'd1,
        COLOR_BLUE  = 3'd2
    } color_e;

    localparam logic EDGE_WRAP = 1'b0;
    localparam logic EDGE_KILL = 1'b1;

    typedef logic [SLOT_COORD_W-1:0]        coord_t;
    typedef logic signed [SLOT_VEL_W-1:0]   vel_t;
    typedef logic [SLOT_COLOR_W-1:0]        color_t;

    typedef struct packed {
        logic   alive;
        coord_t x;
        coord_t y;
        coord_t w;
        coord_t h;
        color_t color;
        vel_t   vx;
        vel_t   vy;
        logic   kill;
    } slot_t;

    typedef struct packed {
        logic   out;   // step left the field on this axis
        coord_t pos;   // wrapped or in-range position
    } axis_t;

    // Two extra bits hold both the carry above 255 and the sign below 0.
    function automatic axis_t axis_step(input coord_t pos, input vel_t vel,
                                        input coord_t field_max);
        logic signed [SLOT_COORD_W+1:0] n;
        axis_t r;
        n = $signed({2'b00, pos})
          + $signed({{(SLOT_COORD_W+2-SLOT_VEL_W){vel[SLOT_VEL_W-1]}}, vel});
        if (n[SLOT_COORD_W+1]) begin
            r.out = 1'b1;
            r.pos = field_max;
        end else if (n > $signed({2'b00, field_max})) begin
            r.out = 1'b1;
            r.pos = coord_t'(1);
        end else begin
            r.out = 1'b0;
            r.pos = n[SLOT_COORD_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// Spawn handshake between the game logic (master) and the bullet pool (slave).
interface bullet_pool_if
    import bullet_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    localparam int IDX_W    = $clog2(NUM_SLOTS)
) ();

    logic             spawn_valid;
    logic             spawn_ready;
    coord_t           spawn_x;
    coord_t           spawn_y;
    coord_t           spawn_w;
    coord_t           spawn_h;
    color_t           spawn_color;
    vel_t             spawn_vx;
    vel_t             spawn_vy;
    logic             spawn_kill;
    logic [IDX_W-1:0] spawn_slot;

    modport master (
        output spawn_valid, spawn_x, spawn_y, spawn_w, spawn_h,
               spawn_color, spawn_vx, spawn_vy, spawn_kill,
        input  spawn_ready, spawn_slot
    );

    modport slave (
        input  spawn_valid, spawn_x, spawn_y, spawn_w, spawn_h,
               spawn_color, spawn_vx, spawn_vy, spawn_kill,
        output spawn_ready, spawn_slot
    );

endinterface

// File: rtl/bullet_free_finder.sv
// Lowest-set-bit priority encoder: picks the lowest free slot of the pool.
module bullet_free_finder #(
    parameter int WIDTH    = 8,
    localparam int IDX_W   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] free_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (free_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bullet_pool.sv
// Pool of projectile slots: spawns over a handshake, moves live bullets on
// tick, retires on collide/edge/clear, and exposes two combinational read ports.
module bullet_pool
    import bullet_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int COORD_W   = SLOT_COORD_W,
    parameter int VEL_W     = SLOT_VEL_W,
    parameter int COLOR_W   = SLOT_COLOR_W,
    parameter int FIELD_MAX = FIELD_MAX_DEF,
    localparam int IDX_W    = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    bullet_pool_if.slave         spawn,
    input  logic [IDX_W-1:0]     rd_idx_a,
    input  logic [IDX_W-1:0]     rd_idx_b,
    output logic [2*COORD_W-1:0] rd_pos_a,
    output logic [2*COORD_W-1:0] rd_pos_b,
    output logic [2*COORD_W-1:0] rd_size_a,
    output logic [2*COORD_W-1:0] rd_size_b,
    output logic [COLOR_W-1:0]   rd_color_a,
    output logic [COLOR_W-1:0]   rd_color_b,
    output logic                 rd_live_a,
    output logic                 rd_live_b,
    input  logic                 collide,
    input  logic                 clear_all,
    output logic [IDX_W:0]       live_count
);

    localparam coord_t FMAX = coord_t'(FIELD_MAX);

    slot_t                slot_q [NUM_SLOTS];
    slot_t                slot_d [NUM_SLOTS];
    logic [IDX_W:0]       live_count_q, live_count_d;
    logic [NUM_SLOTS-1:0] free_mask;
    logic [IDX_W-1:0]     free_idx;
    logic                 free_found;
    logic                 spawn_fire;

    always_comb begin
        free_mask = '0;
        for (int i = 0; i < NUM_SLOTS; i++) free_mask[i] = ~slot_q[i].alive;
    end

    bullet_free_finder #(.WIDTH(NUM_SLOTS)) u_free_finder (
        .free_i  (free_mask),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    assign spawn.spawn_ready = free_found && !clear_all;
    assign spawn.spawn_slot  = free_idx;
    assign spawn_fire        = spawn.spawn_valid && spawn.spawn_ready;

    // Per-slot priority: clear_all, collide (live slots only), spawn, tick.
    always_comb begin
        axis_t ax;
        axis_t ay;
        ax           = '0;
        ay           = '0;
        live_count_d = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_d[i] = slot_q[i];
            ax = axis_step(slot_q[i].x, slot_q[i].vx, FMAX);
            ay = axis_step(slot_q[i].y, slot_q[i].vy, FMAX);
            if (clear_all) begin
                slot_d[i].alive = 1'b0;
            end else if (collide && slot_q[i].alive && rd_idx_b == IDX_W'(i)) begin
                slot_d[i].alive = 1'b0;
            end else if (spawn_fire && free_idx == IDX_W'(i)) begin
                slot_d[i].alive = 1'b1;
                slot_d[i].x     = spawn.spawn_x;
                slot_d[i].y     = spawn.spawn_y;
                slot_d[i].w     = spawn.spawn_w;
                slot_d[i].h     = spawn.spawn_h;
                slot_d[i].color = spawn.spawn_color[COLOR_W-1:0];
                slot_d[i].vx    = spawn.spawn_vx[VEL_W-1:0];
                slot_d[i].vy    = spawn.spawn_vy[VEL_W-1:0];
                slot_d[i].kill  = spawn.spawn_kill;
            end else if (tick && slot_q[i].alive) begin
                if (slot_q[i].kill && (ax.out || ay.out)) begin
                    slot_d[i].alive = 1'b0;
                end else begin
                    slot_d[i].x = ax.pos;
                    slot_d[i].y = ay.pos;
                end
            end
            live_count_d = live_count_d + (IDX_W+1)'(slot_d[i].alive);
        end
    end

    // NOTE: slot storage is plain flops, so a full reset of every field is cheap and keeps reads defined.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
            live_count_q <= '0;
        end else begin
            slot_q       <= slot_d;
            live_count_q <= live_count_d;
        end
    end

    assign live_count = live_count_q;

    assign rd_pos_a   = {slot_q[rd_idx_a].y, slot_q[rd_idx_a].x};
    assign rd_size_a  = {slot_q[rd_idx_a].h, slot_q[rd_idx_a].w};
    assign rd_color_a = slot_q[rd_idx_a].color;
    assign rd_live_a  = slot_q[rd_idx_a].alive;

    assign rd_pos_b   = {slot_q[rd_idx_b].y, slot_q[rd_idx_b].x};
    assign rd_size_b  = {slot_q[rd_idx_b].h, slot_q[rd_idx_b].w};
    assign rd_color_b = slot_q[rd_idx_b].color;
    assign rd_live_b  = slot_q[rd_idx_b].alive;

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: a table of single-bullet motion vectors
// followed by hand-written multi-cycle sequences.
module tb_bullet_pool;
    import bullet_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic        collide = 1'b0;
    logic        clear_all = 1'b0;
    logic [2:0]  rd_idx_a = '0;
    logic [2:0]  rd_idx_b = '0;
    logic [15:0] rd_pos_a, rd_pos_b, rd_size_a, rd_size_b;
    logic [2:0]  rd_color_a, rd_color_b;
    logic        rd_live_a, rd_live_b;
    logic [3:0]  live_count;

    int n_tests = 0;
    int n_fail  = 0;

    bullet_pool_if #(.NUM_SLOTS(8)) sif ();

    bullet_pool #(.NUM_SLOTS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .spawn      (sif),
        .rd_idx_a   (rd_idx_a),
        .rd_idx_b   (rd_idx_b),
        .rd_pos_a   (rd_pos_a),
        .rd_pos_b   (rd_pos_b),
        .rd_size_a  (rd_size_a),
        .rd_size_b  (rd_size_b),
        .rd_color_a (rd_color_a),
        .rd_color_b (rd_color_b),
        .rd_live_a  (rd_live_a),
        .rd_live_b  (rd_live_b),
        .collide    (collide),
        .clear_all  (clear_all),
        .live_count (live_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]        x, y;
        logic signed [3:0] vx, vy;
        logic              kill;
        logic              exp_live;
        logic [7:0]        exp_x, exp_y;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_spawn(input int x, input int y, input int vx, input int vy, input logic kill);
        sif.spawn_valid = 1'b1;
        sif.spawn_x     = 8'(x);
        sif.spawn_y     = 8'(y);
        sif.spawn_w     = 8'd4;
        sif.spawn_h     = 8'd2;
        sif.spawn_color = COLOR_GREEN;
        sif.spawn_vx    = 4'(vx);
        sif.spawn_vy    = 4'(vy);
        sif.spawn_kill  = kill;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic read_a(input int idx);
        rd_idx_a = 3'(idx);
        #1;
    endtask

    task automatic read_b(input int idx);
        rd_idx_b = 3'(idx);
        #1;
    endtask

    // Spawns slot k at (10k, k) with vx=+1; optionally checks the grant per step.
    task automatic fill_pool(input bit do_check);
        for (int k = 0; k < 8; k++) begin
            set_spawn(10 * k, k, 1, 0, EDGE_WRAP);
            #1;
            if (do_check) begin
                check("fill_ready", 32'(sif.spawn_ready), 32'd1);
                check("fill_slot", 32'(sif.spawn_slot), 32'(k));
            end
            cycle();
        end
        sif.spawn_valid = 1'b0;
    endtask

    task automatic all_dead(input string name);
        logic any_live;
        any_live = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read_a(i);
            any_live = any_live | rd_live_a;
        end
        check(name, 32'(any_live), 32'd0);
    endtask

    initial begin
        int ys [4];
        ys = '{189, 194, 199, 1};
        //        x    y    vx   vy  kill  live  ex   ey
        vecs[0]  = '{8'd36,  8'd19,  4'sd0,  4'sd5,  1'b0, 1'b1, 8'd36,  8'd24};
        vecs[1]  = '{8'd198, 8'd50,  4'sd3,  4'sd0,  1'b1, 1'b0, 8'd198, 8'd50};
        vecs[2]  = '{8'd1,   8'd50, -4'sd2,  4'sd0,  1'b0, 1'b1, 8'd200, 8'd50};
        vecs[3]  = '{8'd198, 8'd50,  4'sd3,  4'sd0,  1'b0, 1'b1, 8'd1,   8'd50};
        vecs[4]  = '{8'd10,  8'd0,   4'sd0, -4'sd1,  1'b1, 1'b0, 8'd10,  8'd0};
        vecs[5]  = '{8'd10,  8'd0,   4'sd0, -4'sd1,  1'b0, 1'b1, 8'd10,  8'd200};
        vecs[6]  = '{8'd200, 8'd200, 4'sd0,  4'sd0,  1'b1, 1'b1, 8'd200, 8'd200};
        vecs[7]  = '{8'd197, 8'd3,   4'sd3, -4'sd3,  1'b1, 1'b1, 8'd200, 8'd0};
        vecs[8]  = '{8'd100, 8'd100,-4'sd8,  4'sd7,  1'b0, 1'b1, 8'd92,  8'd107};
        vecs[9]  = '{8'd200, 8'd5,   4'sd1, -4'sd8,  1'b0, 1'b1, 8'd1,   8'd200};
        vecs[10] = '{8'd255, 8'd10,  4'sd0,  4'sd0,  1'b1, 1'b0, 8'd255, 8'd10};

        sif.spawn_valid = 1'b0;
        set_spawn(0, 0, 0, 0, EDGE_WRAP);
        sif.spawn_valid = 1'b0;

        // Reset state
        do_reset();
        read_a(0);
        check("rst_live_count", 32'(live_count), 32'd0);
        check("rst_ready", 32'(sif.spawn_ready), 32'd1);
        check("rst_slot", 32'(sif.spawn_slot), 32'd0);
        check("rst_live_a", 32'(rd_live_a), 32'd0);
        check("rst_pos_a", 32'(rd_pos_a), 32'd0);

        // Table: one bullet in slot 0, one tick, check outcome
        for (int v = 0; v < 11; v++) begin
            clear_all = 1'b1;
            cycle();
            clear_all = 1'b0;
            set_spawn(vecs[v].x, vecs[v].y, vecs[v].vx, vecs[v].vy, vecs[v].kill);
            #1;
            check($sformatf("vec%0d_slot", v), 32'(sif.spawn_slot), 32'd0);
            cycle();
            sif.spawn_valid = 1'b0;
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            read_a(0);
            check($sformatf("vec%0d_live", v), 32'(rd_live_a), 32'(vecs[v].exp_live));
            check($sformatf("vec%0d_x", v), 32'(rd_pos_a[7:0]), 32'(vecs[v].exp_x));
            check($sformatf("vec%0d_y", v), 32'(rd_pos_a[15:8]), 32'(vecs[v].exp_y));
        end

        // Long vertical flight ending in a wrap
        do_reset();
        set_spawn(36, 19, 0, 5, EDGE_WRAP);
        #1;
        check("fly_slot", 32'(sif.spawn_slot), 32'd0);
        cycle();
        sif.spawn_valid = 1'b0;
        read_a(0);
        check("fly_live", 32'(rd_live_a), 32'd1);
        check("fly_count", 32'(live_count), 32'd1);
        check("fly_size", 32'(rd_size_a), 32'h0204);
        check("fly_color", 32'(rd_color_a), 32'(COLOR_GREEN));
        tick = 1'b1;
        repeat (33) cycle();
        tick = 1'b0;
        check("fly_y33", 32'(rd_pos_a[15:8]), 32'd184);
        for (int k = 0; k < 4; k++) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            check($sformatf("fly_y%0d", 34 + k), 32'(rd_pos_a[15:8]), 32'(ys[k]));
        end
        check("fly_x", 32'(rd_pos_a[7:0]), 32'd36);

        // Fill the pool and stall further requests
        do_reset();
        fill_pool(1'b1);
        check("full_ready", 32'(sif.spawn_ready), 32'd0);
        check("full_count", 32'(live_count), 32'd8);
        set_spawn(99, 99, 0, 0, EDGE_WRAP);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_count", 32'(live_count), 32'd8);
            check("stall_ready", 32'(sif.spawn_ready), 32'd0);
        end
        sif.spawn_valid = 1'b0;
        read_a(0);
        check("stall_s0_x", 32'(rd_pos_a[7:0]), 32'd0);
        read_a(7);
        check("stall_s7_pos", 32'(rd_pos_a), 32'h0746);

        // Kill at edge vs wrap at edge
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_spawn(50, 50, 0, 0, EDGE_WRAP);
            cycle();
        end
        set_spawn(198, 10, 3, 0, EDGE_KILL);
        cycle();
        set_spawn(1, 10, -2, 0, EDGE_WRAP);
        cycle();
        sif.spawn_valid = 1'b0;
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        read_a(3);
        read_b(4);
        check("edge_s3_live", 32'(rd_live_a), 32'd0);
        check("edge_s3_x", 32'(rd_pos_a[7:0]), 32'd198);
        check("edge_s4_live", 32'(rd_live_b), 32'd1);
        check("edge_s4_x", 32'(rd_pos_b[7:0]), 32'd200);
        check("edge_count", 32'(live_count), 32'd4);

        // Collide + tick + spawn on a full pool
        do_reset();
        fill_pool(1'b0);
        collide  = 1'b1;
        rd_idx_b = 3'd2;
        tick     = 1'b1;
        set_spawn(123, 77, 1, 0, EDGE_WRAP);
        #1;
        check("col_ready_pre", 32'(sif.spawn_ready), 32'd0);
        cycle();
        collide = 1'b0;
        read_b(2);
        check("col_s2_live", 32'(rd_live_b), 32'd0);
        check("col_count", 32'(live_count), 32'd7);
        check("col_ready", 32'(sif.spawn_ready), 32'd1);
        check("col_slot", 32'(sif.spawn_slot), 32'd2);
        read_a(5);
        check("col_s5_x", 32'(rd_pos_a[7:0]), 32'd51);
        cycle();
        tick = 1'b0;
        sif.spawn_valid = 1'b0;
        read_b(2);
        read_a(5);
        check("resp_s2_live", 32'(rd_live_b), 32'd1);
        check("resp_s2_x", 32'(rd_pos_b[7:0]), 32'd123);
        check("resp_count", 32'(live_count), 32'd8);
        check("resp_s5_x", 32'(rd_pos_a[7:0]), 32'd52);

        // clear_all while a spawn is requested
        collide  = 1'b1;
        rd_idx_b = 3'd0;
        cycle();
        collide  = 1'b0;
        check("pre_clr_count", 32'(live_count), 32'd7);
        clear_all = 1'b1;
        set_spawn(5, 5, 0, 0, EDGE_WRAP);
        #1;
        check("clr_ready", 32'(sif.spawn_ready), 32'd0);
        cycle();
        clear_all = 1'b0;
        sif.spawn_valid = 1'b0;
        check("clr_count", 32'(live_count), 32'd0);
        all_dead("clr_all_dead");
        check("clr_ready_after", 32'(sif.spawn_ready), 32'd1);

        // Reset in the middle of activity
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_spawn(20, 20, 1, 1, EDGE_WRAP);
            cycle();
        end
        check("mid_count5", 32'(live_count), 32'd5);
        tick  = 1'b1;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        tick  = 1'b0;
        sif.spawn_valid = 1'b0;
        check("mid_rst_count", 32'(live_count), 32'd0);
        all_dead("mid_rst_dead");
        check("mid_rst_ready", 32'(sif.spawn_ready), 32'd1);
        check("mid_rst_slot", 32'(sif.spawn_slot), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule
